// File: rtl/nfc_cmd_queue_if.sv
// rtl/nfc_cmd_queue_if.sv - push and transfer-request signal bundle for the NFC command queue
interface nfc_cmd_queue_if;
    logic [47:0] nfc_lba;
    logic [23:0] nfc_len;
    logic [15:0] nfc_opcode;
    logic        nfc_valid;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_lba;
    logic [23:0] cmd_len;
    logic [15:0] cmd_opcode;
    logic        cmd_first;
    logic        cmd_last;

    // Environment side: drives commands in, consumes transfer requests.
    modport master (
        output nfc_lba, nfc_len, nfc_opcode, nfc_valid, cmd_ready,
        input  cmd_valid, cmd_lba, cmd_len, cmd_opcode, cmd_first, cmd_last
    );

    // Queue side.
    modport slave (
        input  nfc_lba, nfc_len, nfc_opcode, nfc_valid, cmd_ready,
        output cmd_valid, cmd_lba, cmd_len, cmd_opcode, cmd_first, cmd_last
    );
endinterface

// File: rtl/nfc_cmd_queue.sv
// rtl/nfc_cmd_queue.sv - NFC command FIFO with per-transfer splitting toward the flash controller
module nfc_cmd_queue #(
    parameter int DEPTH    = 8,
    parameter int MAX_XFER = 256,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    nfc_cmd_queue_if.slave bus,
    input  logic          err_clr,
    output logic [CW-1:0] q_count,
    output logic          q_full,
    output logic          q_empty,
    output logic          busy,
    output logic          overflow_err,
    output logic          zero_len_err
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [23:0] MAX_LEN = MAX_XFER[23:0];

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_next;
    logic [87:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [47:0]   cur_lba;
    logic [23:0]   rem;
    logic [15:0]   cur_op;
    logic          first;

    logic [87:0]   head;
    logic [47:0]   head_lba;
    logic [23:0]   head_len;
    logic [15:0]   head_op;

    logic          pop, load, advance, zero_drop, push_ok, xfer_last;

    assign head     = mem[rd_ptr];
    assign head_lba = head[47:0];
    assign head_len = head[71:48];
    assign head_op  = head[87:72];

    assign q_count  = count;
    assign q_full   = (count == CW'(DEPTH));
    assign q_empty  = (count == '0);
    assign busy     = (state != IDLE) || !q_empty;

    // A full queue still accepts a push when the same edge pops the head.
    assign push_ok   = bus.nfc_valid && (!q_full || pop);
    assign xfer_last = (rem <= MAX_LEN);

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bus.nfc_opcode, bus.nfc_len, bus.nfc_lba};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (!push_ok && pop) count <= count - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= IDLE;
        else                state <= state_next;
    end

    // Next state, pop/advance strobes and transfer-request outputs.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        load           = 1'b0;
        advance        = 1'b0;
        zero_drop      = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_lba    = '0;
        bus.cmd_len    = '0;
        bus.cmd_opcode = '0;
        bus.cmd_first  = 1'b0;
        bus.cmd_last   = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_len != '0) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        zero_drop = 1'b1;
                    end
                end
            end
            ISSUE: begin
                bus.cmd_valid  = 1'b1;
                bus.cmd_lba    = cur_lba;
                bus.cmd_len    = xfer_last ? rem : MAX_LEN;
                bus.cmd_opcode = cur_op;
                bus.cmd_first  = first;
                bus.cmd_last   = xfer_last;
                if (bus.cmd_ready) begin
                    if (xfer_last) state_next = IDLE;
                    else           advance    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Current-command registers: loaded on pop, stepped on each non-final handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cur_lba <= '0;
            rem     <= '0;
            cur_op  <= '0;
            first   <= 1'b0;
        end else if (load) begin
            cur_lba <= head_lba;
            rem     <= head_len;
            cur_op  <= head_op;
            first   <= 1'b1;
        end else if (advance) begin
            cur_lba <= cur_lba + 48'(MAX_XFER);
            rem     <= rem - MAX_LEN;
            first   <= 1'b0;
        end
    end

    // Sticky error flags; a clear wins over a same-edge set.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            overflow_err <= 1'b0;
            zero_len_err <= 1'b0;
        end else if (err_clr) begin
            overflow_err <= 1'b0;
            zero_len_err <= 1'b0;
        end else begin
            if (bus.nfc_valid && !push_ok) overflow_err <= 1'b1;
            if (zero_drop)                 zero_len_err <= 1'b1;
        end
    end
endmodule
